max_net_feeder: RTL and testbench
=================================

Name: max_net_feeder

Overview:
- Front-end sequencer for the max_net competitive network.
- Accepts a serial stream of 32-bit activations over a valid/ready handshake and packs four of them into the parallel x_init_1..x_init_4 bus.
- Issues a one-cycle start to max_net, then waits for its done.
- Captures the 4-bit one-hot winner and presents it as a handshaked result with a 2-bit index and an error flag. It has a watchdog timeout.

Parameters:
- DATA_W, 32, activation width; must match the max_net input width.
- TIMEOUT_CYC, 1024, maximum cycles in WAIT before the run is abandoned; must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous soft clear; returns to COLLECT, count=0.
- in_valid  input  1  in_data holds a valid activation.
- in_ready  output  1  feeder can accept a word.
- in_data  input  DATA_W  activation word.
- net_start  output  1  to max_net start.
- x_init_1..x_init_4  output  DATA_W each  to max_net x_init_1..4 (first word received → x_init_1).
- net_done  input  1  from max_net done.
- net_out  input  4  from max_net out, one-hot winner.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_onehot  output  4  captured net_out.
- res_idx  output  2  index of lowest set bit of res_onehot; 0 if none set.
- res_err  output  1  timeout, or res_onehot not exactly one-hot.

Behaviour:
- Reset (rst=0, asynchronous) drives every register to its initial value:
  - state=COLLECT, word count=0, timer=0, done_q=0.
  - x_init_1..4=0, res_onehot=0, res_idx=0, res_err=0.
  - Outputs: in_ready=1 (follows COLLECT), net_start=0, res_valid=0.
- A reset mid-run aborts immediately. No pending start or result survives.
- done_q is a register of net_done, updated every cycle. done_rise = net_done & ~done_q.
- COLLECT:
  - in_ready=1.
  - On in_valid&in_ready, store in_data into slot[count], then count++.
  - On the accept with count==3: go to FIRE, count→0.
  - in_ready is combinational from state only. It never depends on in_valid.
- FIRE:
  - Lasts exactly 1 cycle. net_start=1, in_ready=0, timer cleared.
  - Next state is WAIT.
  - Latency: last word accepted at edge N → net_start high in cycle N+1.
- WAIT:
  - in_ready=0, net_start=0, timer++ each cycle.
  - On done_rise: capture res_onehot=net_out and res_idx; res_err=1 if popcount(net_out)≠1. Go to REPORT.
  - Else, if timer==TIMEOUT_CYC-1: res_onehot=0, res_idx=0, res_err=1, go to REPORT.
  - done_rise on the same cycle as timeout: done_rise wins, so the capture is used.
  - A net_done that is already high on WAIT entry is not a rise. Only a fresh 0→1 edge counts; otherwise the run ends by timeout.
- REPORT:
  - res_valid=1; res_* held stable.
  - On res_ready: go to COLLECT, res_valid→0 next cycle.
  - res_valid must not drop without res_ready (except on flush or reset).
- x_init_1..4 change only on accepted writes in COLLECT. They are stable from FIRE until the next accepted word.
- flush:
  - In any state: next state COLLECT, count=0, timer=0, res_valid=0.
  - x_init and res_* registers keep their values.
  - flush has priority over all other transitions in the same cycle.
  - A word offered with flush is not stored.
- Timer width is clog2(TIMEOUT_CYC). No wrap is possible because the timeout check precedes overflow.
- Throughput: at most one result per 4 accepted words plus the max_net run time plus 2 cycles.

Decomposition:
- Shared package max_net_pkg holds:
  - state encoding: COLLECT=2'd0, FIRE=2'd1, WAIT=2'd2, REPORT=2'd3.
  - N_INPUTS=4.
  - DATA_W default.
- Natural sub-module: onehot_encode4, combinational. Input: 4-bit vector. Outputs: lowest-set index (2 bits) and a one-hot-valid flag.
- The FSM, packing registers and watchdog stay in max_net_feeder.
- Top-level integration instantiates max_net_feeder ahead of max_net in a wrapper; max_net itself is unchanged.

Test Plan:
- Basic run:
  - Stimulus: stream 5, 40, 12, 7 back-to-back; max_net model raises done 20 cycles after start with out=4'b0010.
  - Required: x_init_1..4=5,40,12,7; net_start is a 1-cycle pulse the cycle after the 4th accept; res_onehot=0010, res_idx=1, res_err=0.
- Gapped input with backpressure:
  - Stimulus: in_valid toggling 1,0,0,1,… across the four words; res_ready held low 10 cycles.
  - Required: exactly four words stored in order; in_ready=0 during FIRE/WAIT/REPORT; res_valid and res_* stable for 10 cycles, then drop the cycle after res_ready.
- Timeout:
  - Stimulus: TIMEOUT_CYC=16; net_done never rises.
  - Required: res_valid rises 16 cycles after FIRE with res_err=1, res_onehot=0, res_idx=0.
- Tie / invalid one-hot:
  - Stimulus: net_out=4'b0110 at done rise.
  - Required: res_idx=1, res_err=1. Repeat with net_out=0 → res_idx=0, res_err=1.
- flush and reset mid-operation:
  - flush: assert in WAIT after 2 cycles → COLLECT next cycle, in_ready=1, count=0, and a later done rise is ignored.
  - reset: assert rst=0 asynchronously in REPORT → res_valid=0 and net_start=0 immediately, without a clock edge.
- Stale done:
  - Stimulus: net_done held high across FIRE and WAIT entry, falls at +3, rises again at +8.
  - Required: capture happens at the +8 rise only.

Source files
------------

// File: rtl/max_net_pkg.sv
// Shared definitions for the max_net front end: sequencer state encoding and
// the network input geometry.
package max_net_pkg;

  localparam int N_INPUTS   = 4;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FIRE    = 2'd1,
    WAIT    = 2'd2,
    REPORT  = 2'd3
  } state_e;

endpackage

// File: rtl/onehot_encode4.sv
// Lowest-set-bit encoder for a 4-bit winner vector, plus a flag telling
// whether exactly one bit is set.
module onehot_encode4 (
  input  logic [3:0] vec_i,
  output logic [1:0] idx_o,
  output logic       onehot_o
);

  always_comb begin
    idx_o = 2'd0;
    if (vec_i[0])      idx_o = 2'd0;
    else if (vec_i[1]) idx_o = 2'd1;
    else if (vec_i[2]) idx_o = 2'd2;
    else if (vec_i[3]) idx_o = 2'd3;
  end

  // Non-zero with no second bit set: clearing the lowest set bit leaves zero.
  assign onehot_o = (vec_i != 4'd0) && ((vec_i & (vec_i - 4'd1)) == 4'd0);

endmodule

// File: rtl/max_net_feeder.sv
// Sequencer in front of max_net: packs four streamed activations, pulses
// start, waits for a fresh done edge (with watchdog) and reports the winner.
module max_net_feeder
  import max_net_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              net_start,
  output logic [DATA_W-1:0] x_init_1,
  output logic [DATA_W-1:0] x_init_2,
  output logic [DATA_W-1:0] x_init_3,
  output logic [DATA_W-1:0] x_init_4,
  input  logic              net_done,
  input  logic [3:0]        net_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_onehot,
  output logic [1:0]        res_idx,
  output logic              res_err,
  output logic [1:0]        dbg_state,
  output logic [1:0]        dbg_count
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  state_e                             state_q;
  logic [1:0]                         count_q;
  logic [TIMER_W-1:0]                 timer_q;
  logic                               done_q;
  logic [N_INPUTS-1:0][DATA_W-1:0]    slot_q;
  logic [3:0]                         res_onehot_q;
  logic [1:0]                         res_idx_q;
  logic                               res_err_q;

  logic       done_rise;
  logic [1:0] enc_idx;
  logic       enc_onehot;

  onehot_encode4 u_enc (
    .vec_i    (net_out),
    .idx_o    (enc_idx),
    .onehot_o (enc_onehot)
  );

  // Handshakes: a word transfers on a rising edge where in_valid && in_ready;
  // a result transfers where res_valid && res_ready. Ready/valid come from
  // state only, and res_valid holds until taken (flush/reset excepted).
  assign in_ready  = (state_q == COLLECT);
  assign net_start = (state_q == FIRE);
  assign res_valid = (state_q == REPORT);
  assign done_rise = net_done & ~done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= COLLECT;
      count_q      <= 2'd0;
      timer_q      <= '0;
      done_q       <= 1'b0;
      slot_q       <= '0;
      res_onehot_q <= 4'd0;
      res_idx_q    <= 2'd0;
      res_err_q    <= 1'b0;
    end else begin
      done_q <= net_done;
      if (flush) begin
        state_q <= COLLECT;
        count_q <= 2'd0;
        timer_q <= '0;
      end else begin
        case (state_q)
          COLLECT: begin
            if (in_valid) begin
              slot_q[count_q] <= in_data;
              count_q         <= count_q + 2'd1;
              if (count_q == 2'd3) state_q <= FIRE;
            end
          end
          FIRE: begin
            timer_q <= '0;
            state_q <= WAIT;
          end
          WAIT: begin
            // A capture on the timeout cycle still wins over the watchdog.
            if (done_rise) begin
              res_onehot_q <= net_out;
              res_idx_q    <= enc_idx;
              res_err_q    <= ~enc_onehot;
              state_q      <= REPORT;
            end else if (timer_q == TIMER_LAST) begin
              res_onehot_q <= 4'd0;
              res_idx_q    <= 2'd0;
              res_err_q    <= 1'b1;
              state_q      <= REPORT;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          REPORT: begin
            if (res_ready) state_q <= COLLECT;
          end
          default: state_q <= COLLECT;
        endcase
      end
    end
  end

  assign x_init_1   = slot_q[0];
  assign x_init_2   = slot_q[1];
  assign x_init_3   = slot_q[2];
  assign x_init_4   = slot_q[3];
  assign res_onehot = res_onehot_q;
  assign res_idx    = res_idx_q;
  assign res_err    = res_err_q;
  assign dbg_state  = state_q;
  assign dbg_count  = count_q;

endmodule

// File: tb/tb_max_net_feeder.sv
// Directed bench for max_net_feeder: one main instance plus a short-watchdog
// instance sharing the same stimulus.
module tb_max_net_feeder;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          net_done;
  logic [3:0]    net_out;
  logic          res_ready;

  logic          in_ready, net_start, res_valid, res_err;
  logic [DW-1:0] x1, x2, x3, x4;
  logic [3:0]    res_onehot;
  logic [1:0]    res_idx, dbg_state, dbg_count;

  logic          t_in_ready, t_net_start, t_res_valid, t_res_err;
  logic [DW-1:0] t_x1, t_x2, t_x3, t_x4;
  logic [3:0]    t_res_onehot;
  logic [1:0]    t_res_idx, t_dbg_state, t_dbg_count;

  int n_vec = 0;
  int n_err = 0;

  max_net_feeder #(.DATA_W(DW), .TIMEOUT_CYC(1024)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .net_start(net_start),
    .x_init_1(x1), .x_init_2(x2), .x_init_3(x3), .x_init_4(x4),
    .net_done(net_done), .net_out(net_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_onehot(res_onehot), .res_idx(res_idx), .res_err(res_err),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  max_net_feeder #(.DATA_W(DW), .TIMEOUT_CYC(16)) dut_to (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
    .net_start(t_net_start),
    .x_init_1(t_x1), .x_init_2(t_x2), .x_init_3(t_x3), .x_init_4(t_x4),
    .net_done(net_done), .net_out(net_out),
    .res_valid(t_res_valid), .res_ready(res_ready),
    .res_onehot(t_res_onehot), .res_idx(t_res_idx), .res_err(t_res_err),
    .dbg_state(t_dbg_state), .dbg_count(t_dbg_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not reach summary, required finish");
    $fatal(1, "global timeout");
  end

  // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic stream4(input logic [DW-1:0] w0, w1, w2, w3, input int gap);
    logic [DW-1:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_data  = 32'hdead_0000 + DW'(g);
          tick();
        end
      end
      in_valid = 1'b1;
      in_data  = w[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    n_vec++; if (net_start !== 1'b0) begin n_err++; $display("FAIL reset_net_start: got %b exp 0", net_start); end
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b exp 0", res_valid); end
    n_vec++; if ({x1, x2, x3, x4} !== 128'd0) begin n_err++; $display("FAIL reset_x_init: got %h %h %h %h exp 0", x1, x2, x3, x4); end
    n_vec++; if ({res_onehot, res_idx, res_err} !== 7'd0) begin n_err++; $display("FAIL reset_res: got %b %0d %b exp 0", res_onehot, res_idx, res_err); end
    n_vec++; if (dbg_state !== 2'd0 || dbg_count !== 2'd0) begin n_err++; $display("FAIL reset_state: got st=%0d cnt=%0d exp 0/0", dbg_state, dbg_count); end
  endtask

  task automatic test_basic();
    do_flush();
    stream4(32'd5, 32'd40, 32'd12, 32'd7, 0);
    n_vec++; if (net_start !== 1'b1) begin n_err++; $display("FAIL basic_start: got %b exp 1", net_start); end
    n_vec++; if (x1 !== 32'd5 || x2 !== 32'd40 || x3 !== 32'd12 || x4 !== 32'd7) begin
      n_err++; $display("FAIL basic_x_init: got %0d %0d %0d %0d exp 5 40 12 7", x1, x2, x3, x4); end
    tick();
    n_vec++; if (net_start !== 1'b0) begin n_err++; $display("FAIL basic_start_pulse: got %b exp 0", net_start); end
    // max_net model answers 20 cycles after start
    for (int i = 0; i < 19; i++) tick();
    net_done = 1'b1;
    net_out  = 4'b0010;
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b exp 0", res_valid); end
    tick();
    n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL basic_res_valid: got %b exp 1", res_valid); end
    n_vec++; if (res_onehot !== 4'b0010 || res_idx !== 2'd1 || res_err !== 1'b0) begin
      n_err++; $display("FAIL basic_result: got %b/%0d/%b exp 0010/1/0", res_onehot, res_idx, res_err); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    net_done  = 1'b0;
    n_vec++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_release: got valid=%b ready=%b exp 0/1", res_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    logic [3:0] held_oh;
    do_flush();
    stream4(32'd11, 32'd22, 32'd33, 32'd44, 2);
    n_vec++; if (x1 !== 32'd11 || x2 !== 32'd22 || x3 !== 32'd33 || x4 !== 32'd44) begin
      n_err++; $display("FAIL bp_x_init: got %0d %0d %0d %0d exp 11 22 33 44", x1, x2, x3, x4); end
    n_vec++; if (in_ready !== 1'b0 || net_start !== 1'b1) begin
      n_err++; $display("FAIL bp_fire: got ready=%b start=%b exp 0/1", in_ready, net_start); end
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_wait_ready: got %b exp 0", in_ready); end
    end
    net_done = 1'b1;
    net_out  = 4'b1000;
    tick();
    held_oh = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (res_valid !== 1'b1 || res_onehot !== held_oh || res_idx !== 2'd3 || res_err !== 1'b0 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold: cyc %0d got v=%b %b/%0d/%b rdy=%b exp 1 1000/3/0 rdy 0",
                          i, res_valid, res_onehot, res_idx, res_err, in_ready); end
      net_out = 4'b0001;
      tick();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    net_done  = 1'b0;
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL bp_drop: got %b exp 0", res_valid); end
    n_vec++; if (x1 !== 32'd11 || x4 !== 32'd44) begin
      n_err++; $display("FAIL bp_no_store: got %0d %0d exp 11 44", x1, x4); end
  endtask

  task automatic test_timeout();
    int waited;
    do_flush();
    net_done = 1'b0;
    stream4(32'd1, 32'd2, 32'd3, 32'd4, 0);
    n_vec++; if (t_net_start !== 1'b1) begin n_err++; $display("FAIL to_start: got %b exp 1", t_net_start); end
    waited = 0;
    while (t_res_valid !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    // One FIRE cycle, then 16 WAIT cycles, then REPORT
    n_vec++; if (waited !== 17) begin n_err++; $display("FAIL to_latency: got %0d exp 17", waited); end
    n_vec++; if (t_res_err !== 1'b1 || t_res_onehot !== 4'd0 || t_res_idx !== 2'd0) begin
      n_err++; $display("FAIL to_result: got %b/%0d/%b exp 0000/0/1", t_res_onehot, t_res_idx, t_res_err); end
    n_vec++; if (res_valid !== 1'b0 || dbg_state !== 2'd2) begin
      n_err++; $display("FAIL to_long_wait: got v=%b st=%0d exp 0/2", res_valid, dbg_state); end
    do_flush();
  endtask

  task automatic test_tie();
    logic [3:0] pat [2];
    logic [1:0] exp_idx [2];
    pat[0] = 4'b0110; exp_idx[0] = 2'd1;
    pat[1] = 4'b0000; exp_idx[1] = 2'd0;
    for (int k = 0; k < 2; k++) begin
      do_flush();
      stream4(32'd9, 32'd9, 32'd9, 32'd9, 0);
      for (int i = 0; i < 3; i++) tick();
      net_done = 1'b1;
      net_out  = pat[k];
      tick();
      n_vec++; if (res_valid !== 1'b1 || res_onehot !== pat[k] || res_idx !== exp_idx[k] || res_err !== 1'b1) begin
        n_err++; $display("FAIL tie_%0d: got v=%b %b/%0d/%b exp 1 %b/%0d/1",
                          k, res_valid, res_onehot, res_idx, res_err, pat[k], exp_idx[k]); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      net_done  = 1'b0;
    end
  endtask

  task automatic test_flush();
    do_flush();
    stream4(32'd100, 32'd200, 32'd300, 32'd400, 0);
    tick();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++; if (dbg_state !== 2'd0 || in_ready !== 1'b1 || dbg_count !== 2'd0) begin
      n_err++; $display("FAIL flush_wait: got st=%0d rdy=%b cnt=%0d exp 0/1/0", dbg_state, in_ready, dbg_count); end
    n_vec++; if (x1 !== 32'd100 || x4 !== 32'd400) begin
      n_err++; $display("FAIL flush_keep_x: got %0d %0d exp 100 400", x1, x4); end
    net_done = 1'b1;
    net_out  = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    n_vec++; if (res_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++; $display("FAIL flush_ignore_done: got v=%b st=%0d exp 0/0", res_valid, dbg_state); end
    net_done = 1'b0;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd77;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_vec++; if (dbg_count !== 2'd0 || x1 !== 32'd100) begin
      n_err++; $display("FAIL flush_word_dropped: got cnt=%0d x1=%0d exp 0/100", dbg_count, x1); end
  endtask

  task automatic test_reset_report();
    do_flush();
    stream4(32'd8, 32'd6, 32'd4, 32'd2, 0);
    tick();
    net_done = 1'b1;
    net_out  = 4'b0100;
    tick();
    n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL rr_report: got %b exp 1", res_valid); end
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if (res_valid !== 1'b0 || net_start !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL rr_async: got v=%b start=%b rdy=%b exp 0/0/1", res_valid, net_start, in_ready); end
    n_vec++; if (res_onehot !== 4'd0 || x1 !== 32'd0) begin
      n_err++; $display("FAIL rr_regs: got oh=%b x1=%0d exp 0000/0", res_onehot, x1); end
    net_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_stale_done();
    do_flush();
    net_done = 1'b1;
    net_out  = 4'b0001;
    stream4(32'd3, 32'd1, 32'd4, 32'd1, 0);
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 3) net_done = 1'b0;
      n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL stale_early: t=%0d got %b exp 0", t, res_valid); end
    end
    net_done = 1'b1;
    net_out  = 4'b0100;
    tick();
    n_vec++; if (res_valid !== 1'b1 || res_onehot !== 4'b0100 || res_idx !== 2'd2 || res_err !== 1'b0) begin
      n_err++; $display("FAIL stale_capture: got v=%b %b/%0d/%b exp 1 0100/2/0", res_valid, res_onehot, res_idx, res_err); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    net_done  = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    net_done  = 1'b0;
    net_out   = 4'd0;
    res_ready = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    test_basic();
    test_backpressure();
    test_timeout();
    test_tie();
    test_flush();
    test_reset_report();
    test_stale_done();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
